// File: rtl/mac_window_feeder.sv
// Raster pixel stream to 3x3 valid-padding windows for the 9-tap SD4 MAC,
// with a tag pipe that matches MAC latency and collects results in window order.
module mac_window_feeder #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int MAC_LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wt_load,
    input  logic [35:0] wt_in,
    input  logic [4:0]  bias_in,
    input  logic        start,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_in,
    output logic [71:0] image,
    output logic [35:0] weight,
    output logic [4:0]  exp_bias,
    output logic        mac_in_valid,
    input  logic [15:0] mac_out,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        res_last,
    output logic        busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state_reg, state_next;

    logic [CW-1:0] col_reg, col_next;
    logic [RW-1:0] row_reg, row_next;

    logic          pix_ready_reg;
    logic          busy_reg;
    logic [35:0]   weight_reg;
    logic [4:0]    exp_bias_reg;
    logic [71:0]   image_reg;
    logic          mac_in_valid_reg;
    logic          mac_in_last_reg;
    logic [MAC_LAT-1:0] tag_reg;
    logic [MAC_LAT-1:0] last_pipe_reg;
    logic          res_valid_reg;
    logic [15:0]   res_data_reg;
    logic          res_last_reg;

    logic [7:0]    lb0_mem [IMG_W];
    logic [7:0]    lb1_mem [IMG_W];
    logic [7:0]    lb0_rd_reg;
    logic [7:0]    lb1_rd_reg;

    logic [71:0]   window_next;
    logic          accept;
    logic          at_last_col;
    logic          at_last_row;
    logic          frame_end;
    logic          emit;
    logic          drain_done;

    assign accept      = pix_valid & pix_ready_reg;
    assign at_last_col = (col_reg == COL_MAX);
    assign at_last_row = (row_reg == ROW_MAX);
    assign frame_end   = accept & at_last_col & at_last_row;
    assign emit        = accept && (row_reg >= RW'(2)) && (col_reg >= CW'(2));
    assign drain_done  = tag_reg[MAC_LAT-1] & last_pipe_reg[MAC_LAT-1];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (frame_end) state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (state_reg == IDLE && start) begin
            col_next = '0;
            row_next = '0;
        end else if (accept) begin
            if (at_last_col) begin
                col_next = '0;
                if (!at_last_row) row_next = row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    // Read address runs one pixel ahead so the two older rows of the incoming
    // column are already registered when that pixel is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_mem[col_reg] <= lb1_rd_reg;
            lb1_mem[col_reg] <= pix_in;
        end
        lb0_rd_reg <= lb0_mem[col_next];
        lb1_rd_reg <= lb1_mem[col_next];
    end

    // Each window row keeps its two older columns; the newest column is live.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            logic [7:0] c1_reg;
            logic [7:0] c2_reg;
            logic [7:0] new_pix;

            assign new_pix = (gi == 0) ? lb0_rd_reg :
                             (gi == 1) ? lb1_rd_reg : pix_in;

            assign window_next[71-24*gi -: 8] = c1_reg;
            assign window_next[63-24*gi -: 8] = c2_reg;
            assign window_next[55-24*gi -: 8] = new_pix;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    c1_reg <= '0;
                    c2_reg <= '0;
                end else if (accept) begin
                    c1_reg <= c2_reg;
                    c2_reg <= new_pix;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            col_reg          <= '0;
            row_reg          <= '0;
            pix_ready_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            weight_reg       <= '0;
            exp_bias_reg     <= '0;
            image_reg        <= '0;
            mac_in_valid_reg <= 1'b0;
            mac_in_last_reg  <= 1'b0;
            tag_reg          <= '0;
            last_pipe_reg    <= '0;
            res_valid_reg    <= 1'b0;
            res_data_reg     <= '0;
            res_last_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            col_reg       <= col_next;
            row_reg       <= row_next;
            pix_ready_reg <= (state_next == RUN);
            busy_reg      <= (state_reg != IDLE);

            if (state_reg == IDLE && wt_load) begin
                weight_reg   <= wt_in;
                exp_bias_reg <= bias_in;
            end

            mac_in_valid_reg <= emit;
            mac_in_last_reg  <= emit & frame_end;
            if (emit) image_reg <= window_next;

            tag_reg[0]       <= mac_in_valid_reg;
            last_pipe_reg[0] <= mac_in_last_reg;
            for (int i = 1; i < MAC_LAT; i++) begin
                tag_reg[i]       <= tag_reg[i-1];
                last_pipe_reg[i] <= last_pipe_reg[i-1];
            end

            res_valid_reg <= tag_reg[MAC_LAT-1];
            res_last_reg  <= drain_done;
            if (tag_reg[MAC_LAT-1]) res_data_reg <= mac_out;
        end
    end

    assign pix_ready    = pix_ready_reg;
    assign busy         = busy_reg;
    assign weight       = weight_reg;
    assign exp_bias     = exp_bias_reg;
    assign image        = image_reg;
    assign mac_in_valid = mac_in_valid_reg;
    assign res_valid    = res_valid_reg;
    assign res_data     = res_data_reg;
    assign res_last     = res_last_reg;

endmodule

// File: tb/tb_mac_window_feeder.sv
// Directed bench for mac_window_feeder on a 4x4 frame with a 5-stage MAC stub.
module tb_mac_window_feeder;

    localparam int W = 4;
    localparam int H = 4;
    localparam int LAT = 5;

    logic        clk;
    logic        rst;
    logic        wt_load;
    logic [35:0] wt_in;
    logic [4:0]  bias_in;
    logic        start;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_in;
    logic [71:0] image;
    logic [35:0] weight;
    logic [4:0]  exp_bias;
    logic        mac_in_valid;
    logic [15:0] mac_out;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_last;
    logic        busy;

    mac_window_feeder #(.IMG_W(W), .IMG_H(H), .MAC_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .wt_load(wt_load), .wt_in(wt_in), .bias_in(bias_in),
        .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_in(pix_in),
        .image(image), .weight(weight), .exp_bias(exp_bias), .mac_in_valid(mac_in_valid),
        .mac_out(mac_out), .res_valid(res_valid), .res_data(res_data),
        .res_last(res_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MAC stub: LAT-stage delay of {tap 8, tap 0}
    logic [15:0] stub [LAT];
    always @(posedge clk) begin
        stub[0] <= {image[7:0], image[71:64]};
        for (int i = 1; i < LAT; i++) stub[i] <= stub[i-1];
    end
    assign mac_out = stub[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [71:0] img_q[$];
    int          win_cyc_q[$];
    logic [15:0] res_q[$];
    logic        last_q[$];
    int          res_cyc_q[$];

    always @(negedge clk) begin
        if (rst) begin
            if (mac_in_valid) begin
                img_q.push_back(image);
                win_cyc_q.push_back(cyc);
            end
            if (res_valid) begin
                res_q.push_back(res_data);
                last_q.push_back(res_last);
                res_cyc_q.push_back(cyc);
            end
        end
    end

    typedef struct {
        int          win_row;
        int          win_col;
        logic [71:0] exp_img;
        logic [15:0] exp_res;
        logic        exp_last;
    } vec_t;
    vec_t vecs [4];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic clear_logs();
        img_q.delete(); win_cyc_q.delete();
        res_q.delete(); last_q.delete(); res_cyc_q.delete();
    endtask

    task automatic start_frame(input bit load);
        @(negedge clk);
        wt_load = load;
        wt_in   = 36'h123456789;
        bias_in = 5'd15;
        start   = 1'b1;
        @(negedge clk);
        wt_load = 1'b0;
        start   = 1'b0;
    endtask

    task automatic feed(input bit bubbles, input bit poke, input int n);
        int  idx = 0;
        int  guard = 0;
        bit  ph = 1'b0;
        bit  acc;
        while (idx < n && guard < 200) begin
            pix_in    = 8'(idx);
            pix_valid = bubbles ? ph : 1'b1;
            ph        = !ph;
            if (poke && idx == 6) begin
                wt_load = 1'b1;
                wt_in   = 36'hFFFFFFFFF;
                bias_in = 5'd3;
                start   = 1'b1;
            end else begin
                wt_load = 1'b0;
                start   = 1'b0;
            end
            acc = pix_valid & pix_ready;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        pix_valid = 1'b0;
        wt_load   = 1'b0;
        start     = 1'b0;
        if (idx < n) chk("feed_timeout", 72'(idx), 72'(n));
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (res_valid && res_last) begin
                seen = 1'b1;
                chk("busy_at_last", 72'(busy), 72'd1);
            end
        end
        if (!seen) chk("drain_timeout", 72'(seen), 72'd1);
        @(negedge clk);
        chk("busy_after_last", 72'(busy), 72'd0);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_win_count"}, 72'(img_q.size()), 72'd4);
        chk({tag, "_res_count"}, 72'(res_q.size()), 72'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < img_q.size() && i < res_q.size()) begin
                chk($sformatf("%s_img_r%0dc%0d", tag, vecs[i].win_row, vecs[i].win_col),
                    img_q[i], vecs[i].exp_img);
                chk($sformatf("%s_res_r%0dc%0d", tag, vecs[i].win_row, vecs[i].win_col),
                    72'(res_q[i]), 72'(vecs[i].exp_res));
                chk($sformatf("%s_last_r%0dc%0d", tag, vecs[i].win_row, vecs[i].win_col),
                    72'(last_q[i]), 72'(vecs[i].exp_last));
                chk($sformatf("%s_lat_r%0dc%0d", tag, vecs[i].win_row, vecs[i].win_col),
                    72'(res_cyc_q[i] - win_cyc_q[i]), 72'(LAT + 1));
            end
        end
    endtask

    initial begin
        vecs[0] = '{2, 2, 72'h00_01_02_04_05_06_08_09_0A, 16'h0A00, 1'b0};
        vecs[1] = '{2, 3, 72'h01_02_03_05_06_07_09_0A_0B, 16'h0B01, 1'b0};
        vecs[2] = '{3, 2, 72'h04_05_06_08_09_0A_0C_0D_0E, 16'h0E04, 1'b0};
        vecs[3] = '{3, 3, 72'h05_06_07_09_0A_0B_0D_0E_0F, 16'h0F05, 1'b1};

        rst = 1'b0; wt_load = 1'b0; wt_in = '0; bias_in = '0;
        start = 1'b0; pix_valid = 1'b0; pix_in = '0;

        // reset state and idle hold
        #12;
        chk("rst_pix_ready", 72'(pix_ready), 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_res_valid", 72'(res_valid), 72'd0);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_pix_ready", 72'(pix_ready), 72'd0);
        chk("idle_busy", 72'(busy), 72'd0);

        // frame 1: back-to-back pixels
        clear_logs();
        start_frame(1'b1);
        feed(1'b0, 1'b0, 16);
        wait_done();
        check_frame("plain");
        chk("weight", 72'(weight), 72'h123456789);
        chk("exp_bias", 72'(exp_bias), 72'd15);

        // frame 2: bubbles every other cycle
        clear_logs();
        start_frame(1'b0);
        feed(1'b1, 1'b0, 16);
        wait_done();
        check_frame("bubble");

        // frame 3: wt_load/start asserted mid-frame must be ignored
        clear_logs();
        start_frame(1'b0);
        feed(1'b0, 1'b1, 16);
        wait_done();
        check_frame("ignore");
        chk("ignore_weight", 72'(weight), 72'h123456789);
        chk("ignore_bias", 72'(exp_bias), 72'd15);

        // abort with one window in flight
        clear_logs();
        start_frame(1'b0);
        feed(1'b0, 1'b0, 11);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("abort_mac_in_valid", 72'(mac_in_valid), 72'd0);
        chk("abort_image", image, 72'd0);
        chk("abort_weight", 72'(weight), 72'd0);
        chk("abort_pix_ready", 72'(pix_ready), 72'd0);
        chk("abort_busy", 72'(busy), 72'd0);
        @(negedge clk); rst = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_win_count", 72'(img_q.size()), 72'd1);
        chk("abort_res_count", 72'(res_q.size()), 72'd0);

        // fresh frame after abort
        clear_logs();
        start_frame(1'b1);
        feed(1'b0, 1'b0, 16);
        wait_done();
        check_frame("after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
